// File: rtl/commitment_engine.sv
// commitment_engine: per-(t, j) party commitment generator for the Picnic-on-SM4
// prover. It walks the parties one at a time through an external hash core, optionally
// folds the aux tape into the last party's hash, and collects every digest into C.
module commitment_engine #(
    parameter int N_PARTIES = 16,
    parameter int SEED_W    = 128,
    parameter int DIGEST_W  = 256,
    parameter int SALT_W    = 256,
    parameter int AUX_W     = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          aux_en,
    input  logic [N_PARTIES*SEED_W-1:0]   seed,
    input  logic [SALT_W-1:0]             salt,
    input  logic [AUX_W-1:0]              aux,
    input  logic [7:0]                    t,
    input  logic [7:0]                    j,
    output logic                          busy,
    output logic                          done,
    output logic [N_PARTIES*DIGEST_W-1:0] C,
    output logic                          h_req,
    output logic [SEED_W-1:0]             h_seed,
    output logic [SALT_W-1:0]             h_salt,
    output logic [7:0]                    h_t,
    output logic [7:0]                    h_j,
    output logic [7:0]                    h_idx,
    output logic                          h_aux_valid,
    output logic [AUX_W-1:0]              h_aux,
    input  logic                          h_ack,
    input  logic [DIGEST_W-1:0]           h_digest
);

    // Hash handshake: h_req is the valid, h_ack is a one-cycle completion strobe.
    // Once h_req rises, it and every h_* field stay stable until the cycle h_ack is
    // sampled high; h_ack may arrive in the very cycle h_req first rises. The request
    // may be withdrawn without an ack only by abort or reset.

    localparam int IDX_W = (N_PARTIES > 1) ? $clog2(N_PARTIES) : 1;
    localparam logic [7:0] LAST_IDX = 8'(N_PARTIES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Visible to bound checkers and waveform viewers.
    state_t state;

    logic [7:0]          idx;
    logic                aux_mode;
    logic [DIGEST_W-1:0] c_mem [N_PARTIES];

    // Job sequencer: request per party, capture digest, pulse done or abandon on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            h_req       <= 1'b0;
            h_aux_valid <= 1'b0;
            idx         <= 8'd0;
            aux_mode    <= 1'b0;
            for (int k = 0; k < N_PARTIES; k++) begin
                c_mem[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_PARTIES; k++) begin
                            c_mem[k] <= '0;
                        end
                        aux_mode <= aux_en;
                        idx      <= 8'd0;
                        busy     <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (abort) begin
                        h_req       <= 1'b0;
                        h_aux_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        h_req       <= 1'b1;
                        h_aux_valid <= aux_mode && (idx == LAST_IDX);
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Abort wins over a digest arriving in the same cycle.
                    if (abort) begin
                        h_req       <= 1'b0;
                        h_aux_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else if (h_ack) begin
                        c_mem[idx[IDX_W-1:0]] <= h_digest;
                        h_req       <= 1'b0;
                        h_aux_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Seed mux: party k lives at slice k counted from the MSB end of seed.
    always_comb begin
        h_seed = '0;
        for (int k = 0; k < N_PARTIES; k++) begin
            if (idx[IDX_W-1:0] == IDX_W'(k)) begin
                h_seed = seed[(N_PARTIES-1-k)*SEED_W +: SEED_W];
            end
        end
    end

    // Pack the commitment slots so party 0 lands in the MSBs of C.
    always_comb begin
        C = '0;
        for (int k = 0; k < N_PARTIES; k++) begin
            C[(N_PARTIES-1-k)*DIGEST_W +: DIGEST_W] = c_mem[k];
        end
    end

    assign h_salt = salt;
    assign h_t    = t;
    assign h_j    = j;
    assign h_idx  = idx;
    assign h_aux  = aux;

endmodule

// File: tb/tb_commitment_engine.sv
// tb_commitment_engine: scoreboard bench for commitment_engine with a behavioural
// hash core of programmable latency returning {seed,seed}^idx (^aux on aux requests).
module tb_commitment_engine;

  localparam int N  = 16;
  localparam int SW = 128;
  localparam int DW = 256;
  localparam int LW = 256;
  localparam int AW = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            start;
  logic            abort_main;
  logic            abort_model = 1'b0;
  logic            abort;
  logic            aux_en;
  logic [N*SW-1:0] seed;
  logic [LW-1:0]   salt;
  logic [AW-1:0]   aux;
  logic [7:0]      t;
  logic [7:0]      j;
  logic            busy;
  logic            done;
  logic [N*DW-1:0] C;
  logic            h_req;
  logic [SW-1:0]   h_seed;
  logic [LW-1:0]   h_salt;
  logic [7:0]      h_t;
  logic [7:0]      h_j;
  logic [7:0]      h_idx;
  logic            h_aux_valid;
  logic [AW-1:0]   h_aux;
  logic            h_ack;
  logic [DW-1:0]   h_digest;

  logic            ack_model = 1'b0;
  logic            ack_spur  = 1'b0;
  logic [DW-1:0]   dig_model = '0;
  logic [DW-1:0]   dig_spur  = '0;

  assign abort    = abort_main | abort_model;
  assign h_ack    = ack_model | ack_spur;
  assign h_digest = ack_spur ? dig_spur : dig_model;

  commitment_engine #(
    .N_PARTIES(N), .SEED_W(SW), .DIGEST_W(DW), .SALT_W(LW), .AUX_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .aux_en(aux_en),
    .seed(seed), .salt(salt), .aux(aux), .t(t), .j(j),
    .busy(busy), .done(done), .C(C),
    .h_req(h_req), .h_seed(h_seed), .h_salt(h_salt), .h_t(h_t), .h_j(h_j),
    .h_idx(h_idx), .h_aux_valid(h_aux_valid), .h_aux(h_aux),
    .h_ack(h_ack), .h_digest(h_digest)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  int   cyc       = 0;
  int   done_cnt  = 0;
  int   done_cyc  = 0;
  int   lat       = 3;
  int   abort_idx = -1;
  logic job_aux   = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- hash core model ----------------
  initial begin
    int cnt;
    logic [7:0] next_idx;
    logic prev_busy;
    logic [SW-1:0] s;
    cnt = 0;
    next_idx = 8'd0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      ack_model   = 1'b0;
      abort_model = 1'b0;
      if (busy === 1'b1 && !prev_busy) next_idx = 8'd0;
      prev_busy = (busy === 1'b1);
      if (h_req !== 1'b1) begin
        cnt = 0;
      end else if (cnt < lat) begin
        cnt++;
      end else begin
        ack_model = 1'b1;
        dig_model = {h_seed, h_seed} ^ DW'(h_idx) ^ (h_aux_valid ? h_aux[DW-1:0] : '0);
        s = SW'(seed >> ((N - 1 - int'(next_idx)) * SW));
        check("h_idx", DW'(h_idx), DW'(next_idx));
        check("h_aux_valid", DW'(h_aux_valid), DW'(job_aux && (next_idx == 8'(N - 1))));
        check("h_seed", DW'(h_seed), DW'(s));
        check("h_pass", DW'({h_t, h_j, h_salt != salt, h_aux != aux}), DW'({t, j, 2'b00}));
        if (int'(h_idx) == abort_idx) abort_model = 1'b1;
        next_idx = next_idx + 8'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic rand_inputs();
    for (int w = 0; w < N * SW / 32; w++) seed[w*32 +: 32] = $urandom;
    for (int w = 0; w < AW / 32; w++) aux[w*32 +: 32] = $urandom;
    for (int w = 0; w < LW / 32; w++) salt[w*32 +: 32] = $urandom;
    t = 8'($urandom_range(0, 255));
    j = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [DW-1:0] exp_slot(input int k, input logic ae);
    logic [SW-1:0] s;
    s = SW'(seed >> ((N - 1 - k) * SW));
    return {s, s} ^ DW'(k) ^ ((ae && k == N - 1) ? aux[DW-1:0] : '0);
  endfunction

  task automatic push_slots(input logic ae, input int upto);
    for (int k = 0; k < N; k++) begin
      if (k < upto) exp_q.push_back(exp_slot(k, ae));
      else exp_q.push_back('0);
    end
  endtask

  task automatic compare_c(input string tag);
    logic [DW-1:0] e;
    for (int k = 0; k < N; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s c[%0d]", tag, k), C[(N-1-k)*DW +: DW], e);
    end
  endtask

  task automatic pulse_start(input logic ae, output int st);
    aux_en = ae;
    start  = 1'b1;
    st     = cyc + 1;
    step(1);
    start  = 1'b0;
    aux_en = ~ae;
  endtask

  // Full job: optional start pokes while busy, optional abort at party ab_idx.
  task automatic run_job(input string tag, input logic ae, input int l, input int ab_idx,
                         input bit poke);
    int st;
    int d0;
    int n;
    rand_inputs();
    lat       = l;
    abort_idx = ab_idx;
    job_aux   = ae;
    push_slots(ae, (ab_idx < 0) ? N : ab_idx);
    d0 = done_cnt;
    pulse_start(ae, st);
    if (ab_idx >= 0) begin
      n = 0;
      while (abort !== 1'b1 && n < 500) begin
        step(1);
        n++;
      end
      check({tag, " abort_seen"}, DW'(abort), DW'(1'b1));
      step(1);
      check({tag, " busy_after_abort"}, DW'(busy), DW'(1'b0));
      check({tag, " h_req_after_abort"}, DW'(h_req), DW'(1'b0));
      step(10);
      check({tag, " no_done"}, DW'(done_cnt), DW'(d0));
    end else begin
      n = 0;
      while (done_cnt == d0 && n < 2000) begin
        if (poke) start = (n >= 20 && n < 23);
        step(1);
        n++;
      end
      start = 1'b0;
      check({tag, " done_seen"}, DW'(done_cnt != d0), DW'(1'b1));
      check({tag, " latency"}, DW'(done_cyc - st), DW'(N * (2 + l) + 1));
      step(1);
      check({tag, " done_one_cycle"}, DW'(done), DW'(1'b0));
      check({tag, " busy_idle"}, DW'(busy), DW'(1'b0));
      step(20);
      check({tag, " single_done"}, DW'(done_cnt), DW'(d0 + 1));
      check({tag, " no_restart"}, DW'(busy), DW'(1'b0));
    end
    abort_idx = -1;
    compare_c(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st;
    int n;
    reset = 1'b1; start = 1'b0; abort_main = 1'b0; aux_en = 1'b0;
    seed = '0; salt = '0; aux = '0; t = 8'd0; j = 8'd0;
    step(3);
    reset = 1'b0;
    step(1);
    check("rst busy", DW'(busy), DW'(1'b0));
    check("rst done", DW'(done), DW'(1'b0));
    check("rst h_req", DW'(h_req), DW'(1'b0));
    check("rst h_aux_valid", DW'(h_aux_valid), DW'(1'b0));
    check("rst h_idx", DW'(h_idx), DW'(8'd0));
    push_slots(1'b0, 0);
    compare_c("rst");

    // Reset mid-job once party 5 is being requested.
    rand_inputs();
    lat = 3;
    job_aux = 1'b0;
    pulse_start(1'b0, st);
    n = 0;
    while (!(h_req === 1'b1 && h_idx == 8'd5) && n < 500) begin
      step(1);
      n++;
    end
    check("midrst reached_idx5", DW'(h_idx), DW'(8'd5));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst busy", DW'(busy), DW'(1'b0));
    check("midrst h_req", DW'(h_req), DW'(1'b0));
    push_slots(1'b0, 0);
    compare_c("midrst");
    step(2);

    run_job("basic", 1'b0, 3, -1, 1'b0);
    run_job("aux", 1'b1, 3, -1, 1'b0);
    run_job("zerolat", 1'b0, 0, -1, 1'b0);
    run_job("zerolat_aux", 1'b1, 0, -1, 1'b0);
    run_job("randlat", 1'($urandom_range(0, 1)), $urandom_range(1, 4), -1, 1'b0);
    run_job("poke", 1'b1, 2, -1, 1'b1);

    // Spurious ack while idle must not disturb the held commitments.
    ack_spur = 1'b1;
    for (int w = 0; w < DW / 32; w++) dig_spur[w*32 +: 32] = $urandom;
    step(1);
    ack_spur = 1'b0;
    step(2);
    check("spur busy", DW'(busy), DW'(1'b0));
    push_slots(1'b1, N);
    compare_c("spur");

    run_job("abort7", 1'b0, 3, 7, 1'b0);
    run_job("abort0_zl", 1'b1, 0, 0, 1'b0);
    run_job("recover", 1'b1, 1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/commitment_engine.md
Name: commitment_engine

Overview:
Parametrised commitment generator for the Picnic-on-SM4 MPC-in-the-head prover.
- For one (round t, instance j), hashes each party's seed together with the salt and indices through an external hash core, one party at a time.
- Optionally folds the auxiliary tape into the last party's commitment.
- Collects all digests into one flat commitment vector for the transcript stage.
- Generalises the fixed 15-party, aux-less commitment loop to N parties, configurable widths, an aux mode, and abort.

Parameters:
N_PARTIES, 16, number of parties/seeds (2..64)
SEED_W, 128, seed width in bits
DIGEST_W, 256, hash digest width in bits
SALT_W, 256, salt width in bits
AUX_W, 1024, auxiliary-tape width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request to commit; sampled in IDLE only
abort  in  1  synchronous cancel of a running job
aux_en  in  1  include aux in last party's hash; sampled with start
seed  in  N_PARTIES*SEED_W  party seeds; party 0 in MSBs; held stable while busy
salt  in  SALT_W  salt
aux  in  AUX_W  auxiliary tape
t  in  8  round index
j  in  8  instance index
busy  out  1  job in progress
done  out  1  one-cycle pulse, job complete
C  out  N_PARTIES*DIGEST_W  commitments; party 0 in MSBs
h_req  out  1  hash request; held until h_ack
h_seed  out  SEED_W  seed of current party
h_salt  out  SALT_W  salt passthrough
h_t  out  8  round index passthrough
h_j  out  8  instance index passthrough
h_idx  out  8  current party index
h_aux_valid  out  1  hash must absorb h_aux
h_aux  out  AUX_W  aux passthrough
h_ack  in  1  digest valid; one-cycle pulse
h_digest  in  DIGEST_W  digest, valid with h_ack

Behaviour:
- Reset, when reset=1 at posedge:
  - State → IDLE.
  - busy, done, h_req, h_aux_valid = 0; idx = 0.
  - All C slots = 0.
  - Reset overrides start, abort and h_ack in the same cycle.
- Ordering: C is {c[0],…,c[N-1]}; c[k] = digest for party k. h_seed = seed slice k, counted from the MSB end.
- IDLE:
  - start=1 → clear all C slots, latch aux_en into aux_mode, idx ← 0, busy ← 1, go to REQ.
  - start while busy is ignored; start must drop and re-rise only after done.
- REQ: next cycle h_req=1, then go to WAIT.
  - h_req stays high and all h_* outputs are stable until h_ack.
  - h_idx = idx.
  - h_aux_valid = aux_mode && idx==N_PARTIES-1; otherwise 0.
- WAIT on h_ack=1:
  - c[idx] ← h_digest, h_req ← 0.
  - idx == N_PARTIES-1 → go to DONE.
  - Otherwise idx ← idx+1 and go to REQ.
  - h_ack arriving in the same cycle h_req first rises is legal (zero-latency hash).
- DONE: done=1 for exactly one cycle, busy ← 0, go to IDLE. C holds until the next accepted start or reset.
- h_ack outside WAIT is ignored; no C slot changes.
- abort=1 while busy (REQ/WAIT):
  - Next state IDLE; h_req ← 0, busy ← 0; no done pulse.
  - C keeps the partial contents.
  - A digest arriving in the same cycle as abort is discarded.
  - The hash core must tolerate request withdrawal.
- abort in IDLE/DONE: no effect. Abort takes priority over h_ack.
- Throughput: one request per party. Job latency = N_PARTIES×(1 + hash latency + 1) + 1 cycles from start to done.
- Index compare uses full 8-bit idx; N_PARTIES ≤ 64, so there is no wrap.

Test Plan:
- Reset: assert reset mid-job at idx=5 → next cycle busy=0, h_req=0, C=0; a following start runs a full job correctly.
- Basic, N=16, aux_en=0, hash model returning {h_seed,h_seed}^h_idx after 3 cycles:
  - 16 requests, h_idx 0..15, h_aux_valid always 0.
  - done pulses once at cycle 16×5+1 after start.
  - c[k] matches the model for every k.
- Aux mode, aux_en=1: h_aux_valid=1 only on the request with h_idx=15 (h_aux=aux); the aux-dependent model digest lands in c[15] only.
- Zero-latency hash (h_ack coincident with h_req): all slots captured, no skipped or duplicated idx, done after 2×16+1 cycles.
- Abort during WAIT at idx=7, with h_ack in the same cycle:
  - No done; c[0..6] are valid and c[7..15] = 0.
  - busy=0 next cycle.
- Spurious h_ack in IDLE and start asserted while busy → no C change, no second job, a single done.
